// File: rtl/ro_trace_reader.sv
// Read-side engine for the RO trace BRAM: credit-limited port-B reads feed a small
// first-word-fall-through FIFO that drains as a valid/ready stream with a last flag.

module ro_trace_reader_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] fifo_count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(FIFO_DEPTH));
endmodule

module ro_trace_reader #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk_200MHz,
  input  logic              rst,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              abort,
  output logic              bram_clk_b,
  output logic              bram_en_b,
  output logic [ADDR_W-1:0] bram_addr_b,
  input  logic [DATA_W-1:0] bram_dout_b,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ZERO_W  = {(ADDR_W+1){1'b0}};
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [ADDR_W:0]         reads_left_r;
  logic [ADDR_W:0]         count_r;
  logic [READ_LATENCY-1:0] rv_r;
  logic [DATA_W-1:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fifo_count_r;
  logic                    push_s;
  logic                    pop_s;
  logic                    issue_s;
  logic [CNT_W-1:0]        in_flight_s;

  assign bram_clk_b = clk_200MHz;
  assign push_s     = rv_r[READ_LATENCY-1];
  assign m_tvalid   = (fifo_count_r != {CNT_W{1'b0}});
  assign m_tdata    = mem_r[rd_ptr_r];
  assign pop_s      = m_tvalid & m_tready;
  assign m_tlast    = m_tvalid & (words_sent == (count_r - ONE_W));

  // Read credit: FIFO occupancy plus reads still in the BRAM pipe must fit the FIFO
  always_comb begin
    in_flight_s = CNT_W'(bram_en_b);
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight_s = in_flight_s + CNT_W'(rv_r[i]);
    end
    if ((state_r == ISSUE) && (reads_left_r != ZERO_W) &&
        ((fifo_count_r + in_flight_s) < (DEPTH_C + CNT_W'(pop_s)))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // FIFO storage; stale writes after an abort are harmless because the pointers reset
  always_ff @(posedge clk_200MHz) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bram_dout_b;
    end
  end

  // Control FSM, read pipe tagging, FIFO pointers and stream bookkeeping
  always_ff @(posedge clk_200MHz or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      reads_left_r <= ZERO_W;
      count_r      <= ZERO_W;
      rv_r         <= {READ_LATENCY{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
      bram_en_b    <= 1'b0;
      bram_addr_b  <= {ADDR_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      words_sent   <= ZERO_W;
    end else if (abort) begin
      state_r      <= IDLE;
      reads_left_r <= ZERO_W;
      rv_r         <= {READ_LATENCY{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
      bram_en_b    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done      <= 1'b0;
      bram_en_b <= issue_s;
      rv_r[0]   <= bram_en_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rv_r[i] <= rv_r[i-1];
      end
      if (issue_s) begin
        bram_addr_b  <= addr_r;
        addr_r       <= addr_r + ADDR_W'(1);
        reads_left_r <= reads_left_r - ONE_W;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        words_sent <= words_sent + ONE_W;
      end
      fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);

      case (state_r)
        IDLE: begin
          if (start_read && (num_samples != ZERO_W)) begin
            // First read goes out straight from IDLE to shorten start latency
            bram_en_b    <= 1'b1;
            bram_addr_b  <= start_addr;
            addr_r       <= start_addr + ADDR_W'(1);
            reads_left_r <= num_samples - ONE_W;
            count_r      <= num_samples;
            words_sent   <= ZERO_W;
            busy         <= 1'b1;
            state_r      <= (num_samples == ONE_W) ? DRAIN : ISSUE;
          end else if (start_read) begin
            done <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (issue_s && (reads_left_r == ONE_W)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_s && m_tlast) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  ro_trace_reader_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk        (clk_200MHz),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .fifo_count (fifo_count_r)
  );
endmodule

// File: tb/tb_ro_trace_reader.sv
// Drives one reader with READ_LATENCY=1 and one with READ_LATENCY=2 from shared stimulus;
// each stream is checked against the expected address/data sequence of the burst.

module tb_ro_trace_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_read;
  logic        abort;
  logic        m_tready;
  logic [16:0] start_addr;
  logic [17:0] num_samples;
  logic [1:0]  bclk, en, tvalid, tlast, busy, done;
  logic [16:0] baddr [2];
  logic [15:0] dout [2];
  logic [15:0] tdata [2];
  logic [17:0] ws [2];
  logic [15:0] stage2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_trace_reader #(.ADDR_W(17), .DATA_W(16), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_rl1 (
    .clk_200MHz(clk), .rst(rst), .start_read(start_read), .start_addr(start_addr),
    .num_samples(num_samples), .abort(abort), .bram_clk_b(bclk[0]), .bram_en_b(en[0]),
    .bram_addr_b(baddr[0]), .bram_dout_b(dout[0]), .m_tdata(tdata[0]), .m_tvalid(tvalid[0]),
    .m_tready(m_tready), .m_tlast(tlast[0]), .busy(busy[0]), .done(done[0]), .words_sent(ws[0]));

  ro_trace_reader #(.ADDR_W(17), .DATA_W(16), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_rl2 (
    .clk_200MHz(clk), .rst(rst), .start_read(start_read), .start_addr(start_addr),
    .num_samples(num_samples), .abort(abort), .bram_clk_b(bclk[1]), .bram_en_b(en[1]),
    .bram_addr_b(baddr[1]), .bram_dout_b(dout[1]), .m_tdata(tdata[1]), .m_tvalid(tvalid[1]),
    .m_tready(m_tready), .m_tlast(tlast[1]), .busy(busy[1]), .done(done[1]), .words_sent(ws[1]));

  function automatic logic [15:0] bval(input logic [16:0] a);
    return a[15:0] ^ {a[16], 15'd0};
  endfunction

  // BRAM models; non-enabled cycles return a poison word
  always @(posedge clk) begin
    dout[0] <= en[0] ? bval(baddr[0]) : 16'hDEAD;
    stage2  <= en[1] ? bval(baddr[1]) : 16'hDEAD;
    dout[1] <= stage2;
  end

  logic [15:0] data_q [2][$];
  logic        last_q [2][$];
  logic [16:0] addr_q [2][$];
  int          hs_q   [2][$];
  int          rise_q [2][$];
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int valid_cnt [2] = '{0, 0};
  int busy_cnt [2] = '{0, 0};
  int stab_err [2] = '{0, 0};
  logic        stalled [2] = '{1'b0, 1'b0};
  logic        prev_v [2] = '{1'b0, 1'b0};
  logic [15:0] held_d [2];
  logic        held_l [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        stalled[k] = 1'b0;
        prev_v[k]  = 1'b0;
      end else begin
        if (en[k]) addr_q[k].push_back(baddr[k]);
        if (tvalid[k]) valid_cnt[k]++;
        if (tvalid[k] && !prev_v[k]) rise_q[k].push_back(cyc);
        if (tvalid[k] && m_tready) begin
          data_q[k].push_back(tdata[k]);
          last_q[k].push_back(tlast[k]);
          hs_q[k].push_back(cyc);
        end
        if (busy[k]) busy_cnt[k]++;
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
        if (stalled[k] && (!tvalid[k] || tdata[k] !== held_d[k] || tlast[k] !== held_l[k]))
          stab_err[k]++;
        stalled[k] = tvalid[k] && !m_tready && !abort;
        held_d[k]  = tdata[k];
        held_l[k]  = tlast[k];
        prev_v[k]  = tvalid[k];
      end
    end
  end

  int b_data [2], b_addr [2], b_done [2], b_valid [2], b_busy [2], b_rise [2];
  int start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s, input int k);
    return $sformatf("%s/rl%0d", s, k + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 2; k++) begin
      b_data[k]  = data_q[k].size();
      b_addr[k]  = addr_q[k].size();
      b_done[k]  = done_cnt[k];
      b_valid[k] = valid_cnt[k];
      b_busy[k]  = busy_cnt[k];
      b_rise[k]  = rise_q[k].size();
    end
  endtask

  task automatic start(input logic [16:0] a, input logic [17:0] n);
    snap();
    start_cyc   = cyc;
    start_read  = 1'b1;
    start_addr  = a;
    num_samples = n;
    tick();
    start_read  = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int pct);
    int c = 0;
    while (!(done_cnt[0] > b_done[0] && done_cnt[1] > b_done[1]) && c < budget) begin
      m_tready = ($urandom_range(0, 99) < pct);
      tick();
      c++;
    end
    check("done_timeout", 32'(c < budget), 32'd1);
    m_tready = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_data(input int k, input logic [16:0] sa, input int n, input int total);
    int nd = data_q[k].size() - b_data[k];
    check(tg("word_count", k), nd, n);
    for (int i = 0; i < n && i < nd; i++) begin
      logic [16:0] a = sa + 17'(i);
      check(tg($sformatf("data[%0d]", i), k), data_q[k][b_data[k] + i], bval(a));
      check(tg($sformatf("last[%0d]", i), k), last_q[k][b_data[k] + i], (i == total - 1));
    end
  endtask

  task automatic check_burst(input logic [16:0] sa, input int n, input bit timed);
    for (int k = 0; k < 2; k++) begin
      int na = addr_q[k].size() - b_addr[k];
      check_data(k, sa, n, n);
      check(tg("read_count", k), na, n);
      for (int i = 0; i < n && i < na; i++) begin
        logic [16:0] a = sa + 17'(i);
        check(tg($sformatf("addr[%0d]", i), k), addr_q[k][b_addr[k] + i], a);
      end
      check(tg("words_sent", k), ws[k], 18'(n));
      check(tg("done_pulses", k), done_cnt[k] - b_done[k], 1);
      if (timed && (data_q[k].size() - b_data[k] == n) && rise_q[k].size() > b_rise[k]) begin
        int lastc = hs_q[k][b_data[k] + n - 1];
        check(tg("back_to_back", k), lastc - hs_q[k][b_data[k]], n - 1);
        check(tg("done_after_last", k), done_cyc[k], lastc + 1);
        check(tg("first_valid_latency_ok", k), 32'((rise_q[k][b_rise[k]] - start_cyc) <= k + 3), 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string s);
    for (int k = 0; k < 2; k++) begin
      check(tg({s, "_en"}, k), en[k], 1'b0);
      check(tg({s, "_addr"}, k), baddr[k], 17'd0);
      check(tg({s, "_tvalid"}, k), tvalid[k], 1'b0);
      check(tg({s, "_tlast"}, k), tlast[k], 1'b0);
      check(tg({s, "_busy"}, k), busy[k], 1'b0);
      check(tg({s, "_done"}, k), done[k], 1'b0);
      check(tg({s, "_words_sent"}, k), ws[k], 18'd0);
    end
  endtask

  initial begin
    logic [16:0] ra;
    int rn;
    rst = 1'b1; start_read = 1'b0; abort = 1'b0; m_tready = 1'b1;
    start_addr = 17'd0; num_samples = 18'd0;
    repeat (3) tick();
    check_reset_outputs("reset");
    for (int k = 0; k < 2; k++) check(tg("bram_clk", k), bclk[k], clk);
    rst = 1'b0;
    tick();

    // Basic 8-word burst, full throughput
    start(17'd0, 18'd8);
    run_until_done(200, 100);
    check_burst(17'd0, 8, 1'b1);

    // Address wrap at the top of memory
    start(17'h1FFFE, 18'd4);
    run_until_done(200, 100);
    check_burst(17'h1FFFE, 4, 1'b1);

    // Sparse ready, then several random bursts
    m_tready = 1'b0;
    start(17'($urandom), 18'd16);
    run_until_done(3000, 30);
    check_burst(17'(start_addr), 16, 1'b0);
    for (int r = 0; r < 3; r++) begin
      ra = 17'($urandom);
      rn = $urandom_range(1, 40);
      start(ra, 18'(rn));
      run_until_done(3000, 50);
      check_burst(ra, rn, 1'b0);
    end

    // Empty burst, then start ignored while busy
    start(17'h00123, 18'd0);
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      check(tg("empty_reads", k), addr_q[k].size() - b_addr[k], 0);
      check(tg("empty_valid", k), valid_cnt[k] - b_valid[k], 0);
      check(tg("empty_busy", k), busy_cnt[k] - b_busy[k], 0);
      check(tg("empty_done", k), done_cnt[k] - b_done[k], 1);
    end
    start(17'h00400, 18'd10);
    repeat (3) tick();
    start_read = 1'b1; start_addr = 17'h05000; num_samples = 18'd5;
    tick();
    start_read = 1'b0;
    run_until_done(300, 100);
    repeat (10) tick();
    check_burst(17'h00400, 10, 1'b0);

    // Credit stops reads on a full FIFO; abort after three handshakes
    m_tready = 1'b0;
    start(17'h00A00, 18'd20);
    repeat (10) tick();
    for (int k = 0; k < 2; k++) check(tg("reads_when_full", k), addr_q[k].size() - b_addr[k], 4);
    m_tready = 1'b1;
    repeat (3) tick();
    m_tready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check(tg("abort_tvalid", k), tvalid[k], 1'b0);
      check(tg("abort_busy", k), busy[k], 1'b0);
      check(tg("abort_words_sent", k), ws[k], 18'd3);
      check_data(k, 17'h00A00, 3, 20);
    end
    snap();
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      check(tg("abort_no_done", k), done_cnt[k] - b_done[k], 0);
      check(tg("abort_no_valid", k), valid_cnt[k] - b_valid[k], 0);
    end
    m_tready = 1'b1;
    start(17'h0BEEF, 18'd6);
    run_until_done(200, 100);
    check_burst(17'h0BEEF, 6, 1'b1);

    // Asynchronous reset between clock edges, mid-burst
    m_tready = 1'b0;
    start(17'd0, 18'd8);
    repeat (4) tick();
    for (int k = 0; k < 2; k++) check(tg("busy_before_rst", k), busy[k], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    m_tready = 1'b1;
    start(17'd0, 18'd8);
    run_until_done(200, 100);
    check_burst(17'd0, 8, 1'b1);

    for (int k = 0; k < 2; k++) check(tg("stall_stability", k), stab_err[k], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
